// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 arbitrated stream multiplexer:
// arbitration modes, FSM state encoding and width helpers.
package mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Index width, never below one bit so single-channel builds still have a sel port.
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_1_arb_arb_pick.sv
// Combinational arbiter: picks one requester, either lowest index first
// or searching upward from a round-robin pointer with wrap to channel 0.
module arb_pick
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int MODE  = MODE_FIXED,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [N_CH-1:0]  o_gnt,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any_req
);

    logic [SEL_W-1:0] w_ptr_eff;
    logic             w_found;

    // Fixed priority is round-robin with the search always starting at channel 0.
    assign w_ptr_eff = (MODE == MODE_RR) ? i_ptr : '0;
    assign o_any_req = |i_req;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        // First pass covers ptr..N_CH-1, second pass wraps to 0..ptr-1.
        for (int i = 0; i < N_CH; i++) begin
            if (!w_found && i_req[i] && (w_ptr_eff <= SEL_W'(i))) begin
                w_found  = 1'b1;
                o_gnt[i] = 1'b1;
                o_idx    = SEL_W'(i);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!w_found && i_req[i] && (w_ptr_eff > SEL_W'(i))) begin
                w_found  = 1'b1;
                o_gnt[i] = 1'b1;
                o_idx    = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux_n_1_arb.sv
// N:1 valid/ready stream mux with packet locking and one registered output stage.
// Handshake: a beat moves on channel i when valid_in[i] && ready_out[i]; downstream accepts when valid_out && ready_in.
module mux_n_1_arb
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = MODE_FIXED,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [N_CH*WIDTH-1:0] d_in,
    input  logic [N_CH-1:0]       valid_in,
    input  logic [N_CH-1:0]       last_in,
    output logic [N_CH-1:0]       ready_out,
    output logic [WIDTH-1:0]      y_out,
    output logic                  valid_out,
    output logic                  last_out,
    output logic [SEL_W-1:0]      sel_out,
    input  logic                  ready_in
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [SEL_W-1:0] r_lock_ch;
    logic [SEL_W-1:0] w_lock_nxt;

    logic [WIDTH-1:0] r_y;
    logic             r_valid;
    logic             r_last;
    logic [SEL_W-1:0] r_sel;

    logic             w_load_en;
    logic [N_CH-1:0]  w_lock_oh;
    logic [N_CH-1:0]  w_req;
    logic [N_CH-1:0]  w_gnt;
    logic [SEL_W-1:0] w_idx;
    logic             w_any;
    logic             w_xfer;
    logic             w_last;
    logic [WIDTH-1:0] w_data;

    assign w_load_en = !r_valid || ready_in;

    always_comb begin
        w_lock_oh = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_lock_ch == SEL_W'(i)) begin
                w_lock_oh[i] = 1'b1;
            end
        end
    end

    // While locked only the owning channel may request, so the arbiter can only grant it.
    assign w_req = (r_state == ST_LOCKED) ? (valid_in & w_lock_oh) : valid_in;

    arb_pick #(
        .N_CH (N_CH),
        .MODE (MODE)
    ) u_arb_pick (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_idx     (w_idx),
        .o_any_req (w_any)
    );

    assign ready_out = w_load_en ? w_gnt : '0;
    assign w_xfer    = w_any && w_load_en;

    always_comb begin
        w_data = '0;
        w_last = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt[i]) begin
                w_data = d_in[i*WIDTH +: WIDTH];
                w_last = last_in[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_ch;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer && !w_last) begin
                    w_state_nxt = ST_LOCKED;
                    w_lock_nxt  = w_idx;
                end
            end
            ST_LOCKED: begin
                if (w_xfer && w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The pointer only advances past a channel once its packet has finished.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if ((MODE == MODE_RR) && w_xfer && w_last) begin
            w_ptr_nxt = (w_idx == SEL_W'(N_CH - 1)) ? '0 : w_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_lock_ch <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_lock_ch <= w_lock_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_y     <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_sel   <= '0;
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_y     <= w_data;
                r_valid <= 1'b1;
                r_last  <= w_last;
                r_sel   <= w_idx;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign y_out     = r_y;
    assign valid_out = r_valid;
    assign last_out  = r_last;
    assign sel_out   = r_sel;

endmodule

// File: tb/tb_mux_n_1_arb.sv
// Directed bench for mux_n_1_arb: fixed-priority N=4, round-robin N=4 and
// round-robin N=3 instances sharing one clock and reset.
module tb_mux_n_1_arb;

    logic clk;
    logic rst_n;

    // fixed priority, 4 channels
    logic [31:0] f_d;
    logic [3:0]  f_valid, f_last, f_ready;
    logic [7:0]  f_y;
    logic        f_vo, f_lo, f_rdy_in;
    logic [1:0]  f_sel;

    // round-robin, 4 channels
    logic [31:0] rr_d;
    logic [3:0]  rr_valid, rr_last, rr_ready;
    logic [7:0]  rr_y;
    logic        rr_vo, rr_lo, rr_rdy_in;
    logic [1:0]  rr_sel;

    // round-robin, 3 channels
    logic [23:0] t_d;
    logic [2:0]  t_valid, t_last, t_ready;
    logic [7:0]  t_y;
    logic        t_vo, t_lo, t_rdy_in;
    logic [1:0]  t_sel;

    int n_cmp;
    int n_err;

    mux_n_1_arb #(.N_CH(4), .WIDTH(8), .MODE(0)) dut_fp (
        .clk_in (clk), .rst_n_in (rst_n), .d_in (f_d), .valid_in (f_valid),
        .last_in (f_last), .ready_out (f_ready), .y_out (f_y), .valid_out (f_vo),
        .last_out (f_lo), .sel_out (f_sel), .ready_in (f_rdy_in)
    );

    mux_n_1_arb #(.N_CH(4), .WIDTH(8), .MODE(1)) dut_rr (
        .clk_in (clk), .rst_n_in (rst_n), .d_in (rr_d), .valid_in (rr_valid),
        .last_in (rr_last), .ready_out (rr_ready), .y_out (rr_y), .valid_out (rr_vo),
        .last_out (rr_lo), .sel_out (rr_sel), .ready_in (rr_rdy_in)
    );

    mux_n_1_arb #(.N_CH(3), .WIDTH(8), .MODE(1)) dut_rr3 (
        .clk_in (clk), .rst_n_in (rst_n), .d_in (t_d), .valid_in (t_valid),
        .last_in (t_last), .ready_out (t_ready), .y_out (t_y), .valid_out (t_vo),
        .last_out (t_lo), .sel_out (t_sel), .ready_in (t_rdy_in)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    int exp_ch[5];

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        f_d = '0;  f_valid = '0;  f_last = '0;  f_rdy_in = 1'b1;
        rr_d = '0; rr_valid = '0; rr_last = '0; rr_rdy_in = 1'b1;
        t_d = '0;  t_valid = '0;  t_last = '0;  t_rdy_in = 1'b1;
        #2;
        check("rst_valid", 32'(f_vo), 32'h0);
        check("rst_y", 32'(f_y), 32'h0);
        check("rst_sel", 32'(f_sel), 32'h0);
        check("rst_last", 32'(f_lo), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // fixed priority: ch1 beats ch3
        f_valid = 4'b1010;
        f_last  = 4'b1111;
        f_d[8 +: 8]  = 8'h11;
        f_d[24 +: 8] = 8'h33;
        settle();
        check("fp_ready_first", 32'(f_ready), 32'h2);
        tick();
        f_valid = 4'b1000;
        settle();
        check("fp_y_ch1", 32'(f_y), 32'h11);
        check("fp_sel_ch1", 32'(f_sel), 32'h1);
        check("fp_valid_ch1", 32'(f_vo), 32'h1);
        check("fp_ready_ch3", 32'(f_ready), 32'h8);
        tick();
        f_valid = 4'b0000;
        check("fp_y_ch3", 32'(f_y), 32'h33);
        check("fp_sel_ch3", 32'(f_sel), 32'h3);
        tick();
        check("fp_idle_valid", 32'(f_vo), 32'h0);
        check("fp_idle_y_hold", 32'(f_y), 32'h33);

        // packet lock on ch2 while ch0 keeps requesting
        f_valid = 4'b0100;
        f_last  = 4'b0001;
        f_d[0 +: 8]  = 8'h0F;
        f_d[16 +: 8] = 8'h21;
        settle();
        check("lk_ready_b1", 32'(f_ready), 32'h4);
        tick();
        f_valid = 4'b0001;
        settle();
        check("lk_ready_drop", 32'(f_ready), 32'h0);
        tick();
        check("lk_drop_valid", 32'(f_vo), 32'h0);
        check("lk_drop_y", 32'(f_y), 32'h21);
        f_valid = 4'b0101;
        f_d[16 +: 8] = 8'h22;
        settle();
        check("lk_ready_b2", 32'(f_ready), 32'h4);
        tick();
        check("lk_y_b2", 32'(f_y), 32'h22);
        f_d[16 +: 8] = 8'h23;
        f_last = 4'b0101;
        settle();
        check("lk_ready_b3", 32'(f_ready), 32'h4);
        tick();
        f_valid = 4'b0001;
        settle();
        check("lk_y_b3", 32'(f_y), 32'h23);
        check("lk_last_b3", 32'(f_lo), 32'h1);
        check("lk_sel_b3", 32'(f_sel), 32'h2);
        check("lk_ready_ch0", 32'(f_ready), 32'h1);
        tick();
        f_valid = 4'b0000;
        check("lk_y_ch0", 32'(f_y), 32'h0F);
        check("lk_sel_ch0", 32'(f_sel), 32'h0);
        tick();

        // backpressure with a held 0x5C beat
        f_valid = 4'b0001;
        f_last  = 4'b0011;
        f_d[0 +: 8] = 8'h5C;
        tick();
        f_rdy_in = 1'b0;
        f_valid  = 4'b0010;
        f_d[8 +: 8] = 8'h6D;
        for (int k = 0; k < 5; k++) begin
            settle();
            check($sformatf("bp_ready_%0d", k), 32'(f_ready), 32'h0);
            check($sformatf("bp_y_%0d", k), 32'(f_y), 32'h5C);
            check($sformatf("bp_sel_%0d", k), 32'(f_sel), 32'h0);
            check($sformatf("bp_last_%0d", k), 32'(f_lo), 32'h1);
            check($sformatf("bp_valid_%0d", k), 32'(f_vo), 32'h1);
            tick();
        end
        f_rdy_in = 1'b1;
        settle();
        check("bp_ready_release", 32'(f_ready), 32'h2);
        tick();
        f_valid = 4'b0000;
        check("bp_y_next", 32'(f_y), 32'h6D);
        check("bp_sel_next", 32'(f_sel), 32'h1);
        tick();

        // reset in the middle of a ch2 packet
        f_valid = 4'b0100;
        f_last  = 4'b0000;
        f_d[16 +: 8] = 8'h44;
        tick();
        rst_n = 1'b0;
        settle();
        check("mr_valid", 32'(f_vo), 32'h0);
        check("mr_y", 32'(f_y), 32'h0);
        check("mr_sel", 32'(f_sel), 32'h0);
        tick();
        rst_n   = 1'b1;
        f_valid = 4'b0010;
        f_last  = 4'b0010;
        f_d[8 +: 8] = 8'h12;
        settle();
        check("mr_ready_ch1", 32'(f_ready), 32'h2);
        tick();
        f_valid = 4'b0000;
        check("mr_y_ch1", 32'(f_y), 32'h12);
        check("mr_sel_ch1", 32'(f_sel), 32'h1);
        tick();

        // round-robin, four channels always valid, single-beat packets
        exp_ch  = '{0, 1, 2, 3, 0};
        rr_d    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        rr_valid = 4'b1111;
        rr_last  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            settle();
            check($sformatf("rr_ready_%0d", k), 32'(rr_ready), 32'(4'b0001 << exp_ch[k]));
            tick();
            check($sformatf("rr_y_%0d", k), 32'(rr_y), 32'(8'hA0 + exp_ch[k]));
            check($sformatf("rr_sel_%0d", k), 32'(rr_sel), 32'(exp_ch[k]));
        end
        rr_valid = 4'b0000;

        // three-channel round-robin wrap
        t_valid = 3'b100;
        t_last  = 3'b111;
        t_d     = {8'h32, 8'h31, 8'h30};
        settle();
        check("w3_ready_ch2", 32'(t_ready), 32'h4);
        tick();
        t_valid = 3'b101;
        settle();
        check("w3_ready_wrap", 32'(t_ready), 32'h1);
        tick();
        check("w3_y_ch0", 32'(t_y), 32'h30);
        check("w3_sel_ch0", 32'(t_sel), 32'h0);
        settle();
        check("w3_ready_ch2b", 32'(t_ready), 32'h4);
        tick();
        check("w3_y_ch2", 32'(t_y), 32'h32);
        check("w3_sel_ch2", 32'(t_sel), 32'h2);
        settle();
        check("w3_ready_wrap2", 32'(t_ready), 32'h1);
        t_valid = 3'b000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_n_1_arb.md
Name: mux_n_1_arb

Overview:
- Parametrised N:1 streaming multiplexer with built-in arbitration, packet locking and one registered output stage.
- Selects one of N_CH valid/ready input channels and forwards its beats to a single output.
- Arbitration is fixed-priority (lowest index wins) or round-robin.
- Sits between multiple producers and a shared downstream consumer; generalises the 4:1 combinational priority mux family.

Parameters:
- N_CH, 4, number of input channels (>=1, any integer, not restricted to powers of two).
- WIDTH, 8, data width per channel.
- MODE, 0, arbitration mode: 0 = fixed priority (channel 0 highest), 1 = round-robin.
- SEL_W, derived localparam, max(1, clog2(N_CH)).

Ports:
- clk_in  input  1  clock, all state on rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- d_in  input  N_CH*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- valid_in  input  N_CH  per-channel beat valid.
- last_in  input  N_CH  per-channel end-of-packet marker.
- ready_out  output  N_CH  per-channel accept.
- y_out  output  WIDTH  registered output data.
- valid_out  output  1  output beat valid.
- last_out  output  1  output end-of-packet.
- sel_out  output  SEL_W  index of the channel that sourced the current output beat.
- ready_in  input  1  downstream accept.

Behaviour:
- Reset (async assert, sync release): y_out=0, valid_out=0, last_out=0, sel_out=0, state=IDLE, rr pointer=0, lock channel=0.
- Reset asserted mid-packet abandons the lock and drops any held output beat.
- Output stage may load when load_en = !valid_out || ready_in.
- Input transfer on channel i occurs when valid_in[i] && ready_out[i].
- Latency: a transferred beat appears on y_out/valid_out the next cycle.
- ready_out is one-hot or zero, never more than one bit high.
- ready_out[g]=1 only when load_en=1 and g is the current grant.
- ready_out is combinational from valid_in, state and ready_in; it is not registered.
- Data/valid/last are never dropped or duplicated. While valid_out=1 and ready_in=0, y_out/last_out/sel_out hold stable.
- On load_en with no transfer: valid_out<=0; y_out, last_out and sel_out hold their values.
- State machine:
  - IDLE: grant = arbitration winner among valid_in. On a transfer with last_in[g]=0, go to LOCKED with lock_ch=g. On a transfer with last_in[g]=1, stay in IDLE.
  - LOCKED: only lock_ch is eligible and other channels see ready_out=0 regardless of valid_in. On a transfer with last_in[lock_ch]=1, go to IDLE.
- Fixed priority: grant = lowest index with valid_in set.
- Round-robin:
  - Search starts at ptr and wraps upward modulo N_CH (wrap from N_CH-1 to 0 also for non-power-of-two N_CH).
  - On any transfer with last=1 from channel c, ptr <= (c+1) mod N_CH.
  - ptr does not move on non-last beats or idle cycles.
- Single-beat packets (last=1 on the first beat) never enter LOCKED.
- No valid_in set: grant irrelevant, ready_out=0.
- N_CH=1: degenerates to a registered pipe stage; sel_out is always 0.
- A channel's valid_in may drop mid-packet: the block stays LOCKED and waits, and does not switch channel.

Decomposition:
- Shared package mux_pkg:
  - MODE_FIXED=0, MODE_RR=1.
  - State encoding ST_IDLE/ST_LOCKED.
  - clog2 helper function.
- One sub-module, arb_pick:
  - Combinational; parameters N_CH, MODE.
  - Inputs: request vector, ptr.
  - Outputs: one-hot grant, binary index, any_req.
- mux_n_1_arb holds the FSM, pointer, lock register and output register.

Test Plan:
- Reset mid-packet: assert rst_n_in=0 while LOCKED on ch2 -> immediately valid_out=0, y_out=0, sel_out=0. After release, a new request on ch1 is granted.
- Fixed priority, N_CH=4, WIDTH=8: valid_in=4'b1010, d_in ch1=0x11, ch3=0x33, all last=1, ready_in=1 -> ready_out=4'b0010; next cycle y_out=0x11, sel_out=1, then ch3 beat 0x33 follows.
- Round-robin, all four valid continuously, single-beat packets d=0xA0+i -> grant order 0,1,2,3,0 on consecutive cycles; y_out sequence A0,A1,A2,A3,A0.
- Packet lock: ch2 sends 3 beats (last on beat 3) while ch0 is valid throughout (fixed mode) -> ch0 ready_out=0 until ch2's last beat transfers; ch0 is granted the next cycle.
- Backpressure: ready_in=0 for 5 cycles with valid_out=1, y_out=0x5C -> y_out/last_out/sel_out stable and all ready_out=0. When ready_in=1, the next beat loads the same cycle with no loss.
- N_CH=3, round-robin wrap: last transfer from ch2 -> ptr=0; with ch0 and ch2 requesting, ch0 wins.
